// File: rtl/exec_pkg.sv
// Shared constants, opcodes and FSM state type for the execute/write-back stage.
package exec_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_MUL,
      S_WB
   } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: the first partial product is folded into the
// start cycle so CYCLES iterations finish with done one cycle after the last one.
module mul_shift_add #(
   parameter int W      = 8,
   parameter int CYCLES = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            product <= b[0] ? {{W{1'b0}}, a} : '0;
            mcand   <= {{(W-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            cnt     <= CW'(CYCLES - 1);
            busy    <= (CYCLES > 1);
            done    <= (CYCLES == 1);
         end else if (busy) begin
            if (mplier[0])
               product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/execute_writeback_stage.sv
// Multi-cycle execute stage: issue -> register read -> ALU/multiply -> single write-back.
// Define MUL_EN to build the shift-add multiplier; otherwise opcode 111 retires as illegal.
//
// state  | meaning
// IDLE   | Issue_ready high, waiting for an instruction
// READ   | source addresses and read enables driven, operands captured
// EXEC   | single-cycle ALU result registered into the write-back outputs
// MUL    | multiplier iterating (MUL_EN builds only)
// WB     | write pulse (legal ops) and Done pulse visible
module execute_writeback_stage
   import exec_pkg::*;
#(
   parameter int DATA_W     = DATA_WIDTH,
   parameter int ADDR_W     = ADDR_WIDTH,
   parameter int MUL_CYCLES = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Issue_valid,
   output logic              Issue_ready,
   input  logic [2:0]        Opcode,
   input  logic [ADDR_W-1:0] Src_A_address,
   input  logic [ADDR_W-1:0] Src_B_address,
   input  logic [ADDR_W-1:0] Dest_address,
   output logic [ADDR_W-1:0] Data_A_address,
   output logic [ADDR_W-1:0] Data_B_address,
   output logic              Enable_Read_Data_A,
   output logic              Enable_Read_Data_B,
   input  logic [DATA_W-1:0] Data_out_A,
   input  logic [DATA_W-1:0] Data_out_B,
   output logic              Enable_write,
   output logic [DATA_W-1:0] Data_write,
   output logic [ADDR_W-1:0] Data_write_address,
   output logic              Zero,
   output logic              Carry,
   output logic              Illegal,
   output logic              Done
);

   state_t            state;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] dest_q;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              alu_legal;

   logic              fin;
   logic              fin_legal;
   logic [DATA_W-1:0] fin_res;
   logic              fin_carry;

   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_legal = 1'b1;
      sum       = {1'b0, op_a} + {1'b0, op_b};
      diff      = {1'b0, op_a} - {1'b0, op_b};
      case (op_q)
         OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_carry = sum[DATA_W];  end
         OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_XOR: alu_res = op_a ^ op_b;
         OP_SHL: begin alu_res = {op_a[DATA_W-2:0], 1'b0}; alu_carry = op_a[DATA_W-1]; end
         OP_MOV: alu_res = op_b;
         default: alu_legal = 1'b0;
      endcase
   end

`ifdef MUL_EN
   logic                mul_start;
   logic                mul_busy;
   logic                mul_done;
   logic [2*DATA_W-1:0] mul_product;

   // Operands go straight from the register file so iteration starts with the READ edge.
   assign mul_start = (state == S_READ) && (op_q == OP_MUL) && !mul_busy;

   mul_shift_add #(
      .W      (DATA_W),
      .CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (Clk),
      .reset   (Reset),
      .start   (mul_start),
      .a       (Data_out_A),
      .b       (Data_out_B),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   always_comb begin
      fin       = (state == S_EXEC);
      fin_legal = alu_legal;
      fin_res   = alu_res;
      fin_carry = alu_carry;
`ifdef MUL_EN
      if (state == S_MUL && mul_done) begin
         fin       = 1'b1;
         fin_legal = 1'b1;
         fin_res   = mul_product[DATA_W-1:0];
         fin_carry = |mul_product[2*DATA_W-1:DATA_W];
      end
`endif
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state              <= S_IDLE;
         Issue_ready        <= 1'b1;
         op_q               <= '0;
         dest_q             <= '0;
         op_a               <= '0;
         op_b               <= '0;
         Data_A_address     <= '0;
         Data_B_address     <= '0;
         Enable_Read_Data_A <= 1'b0;
         Enable_Read_Data_B <= 1'b0;
         Enable_write       <= 1'b0;
         Data_write         <= '0;
         Data_write_address <= '0;
         Zero               <= 1'b0;
         Carry              <= 1'b0;
         Illegal            <= 1'b0;
         Done               <= 1'b0;
      end else begin
         Enable_write       <= 1'b0;
         Done               <= 1'b0;
         Enable_Read_Data_A <= 1'b0;
         Enable_Read_Data_B <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Issue_valid) begin
                  op_q               <= Opcode;
                  dest_q             <= Dest_address;
                  Data_A_address     <= Src_A_address;
                  Data_B_address     <= Src_B_address;
                  Enable_Read_Data_A <= 1'b1;
                  Enable_Read_Data_B <= 1'b1;
                  Issue_ready        <= 1'b0;
                  state              <= S_READ;
               end
            end
            S_READ: begin
               op_a <= Data_out_A;
               op_b <= Data_out_B;
`ifdef MUL_EN
               state <= (op_q == OP_MUL) ? S_MUL : S_EXEC;
`else
               state <= S_EXEC;
`endif
            end
            S_EXEC, S_MUL: begin
               if (fin)
                  state <= S_WB;
            end
            S_WB: begin
               Issue_ready <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Illegal opcodes retire without touching the write port or the flags.
         if (fin) begin
            Done <= 1'b1;
            if (fin_legal) begin
               Enable_write       <= 1'b1;
               Data_write         <= fin_res;
               Data_write_address <= dest_q;
               Zero               <= (fin_res == '0);
               Carry              <= fin_carry;
               Illegal            <= 1'b0;
            end else begin
               Illegal <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Self-checking bench for execute_writeback_stage with a behavioural 8x8 register file.
module tb_execute_writeback_stage;
   import exec_pkg::*;

`ifdef MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Issue_valid;
   logic       Issue_ready;
   logic [2:0] Opcode;
   logic [2:0] Src_A_address, Src_B_address, Dest_address;
   logic [2:0] Data_A_address, Data_B_address;
   logic       Enable_Read_Data_A, Enable_Read_Data_B;
   logic [7:0] Data_out_A, Data_out_B;
   logic       Enable_write;
   logic [7:0] Data_write;
   logic [2:0] Data_write_address;
   logic       Zero, Carry, Illegal, Done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Clk = ~Clk;

   execute_writeback_stage dut (
      .Clk                (Clk),
      .Reset              (Reset),
      .Issue_valid        (Issue_valid),
      .Issue_ready        (Issue_ready),
      .Opcode             (Opcode),
      .Src_A_address      (Src_A_address),
      .Src_B_address      (Src_B_address),
      .Dest_address       (Dest_address),
      .Data_A_address     (Data_A_address),
      .Data_B_address     (Data_B_address),
      .Enable_Read_Data_A (Enable_Read_Data_A),
      .Enable_Read_Data_B (Enable_Read_Data_B),
      .Data_out_A         (Data_out_A),
      .Data_out_B         (Data_out_B),
      .Enable_write       (Enable_write),
      .Data_write         (Data_write),
      .Data_write_address (Data_write_address),
      .Zero               (Zero),
      .Carry              (Carry),
      .Illegal            (Illegal),
      .Done               (Done)
   );

   // Register file: reads return 0 when not enabled so a missing enable is visible.
   logic [7:0] rf [8];
   logic       pre_we = 1'b0;
   logic [2:0] pre_addr = '0;
   logic [7:0] pre_data = '0;

   always @(posedge Clk) begin
      if (pre_we)
         rf[pre_addr] <= pre_data;
      else if (Enable_write)
         rf[Data_write_address] <= Data_write;
   end

   assign Data_out_A = Enable_Read_Data_A ? rf[Data_A_address] : 8'h00;
   assign Data_out_B = Enable_Read_Data_B ? rf[Data_B_address] : 8'h00;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [2:0] addr, input logic [7:0] data);
      @(negedge Clk);
      pre_we   = 1'b1;
      pre_addr = addr;
      pre_data = data;
      @(posedge Clk);
      #1 pre_we = 1'b0;
   endtask

   // Returns with the bench in the Done cycle; lat counts N+lat from the accept cycle N.
   task automatic run_op(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] dst, output int lat);
      @(negedge Clk);
      check("ready_at_issue", int'(Issue_ready), 1);
      Issue_valid   = 1'b1;
      Opcode        = op;
      Src_A_address = sa;
      Src_B_address = sb;
      Dest_address  = dst;
      @(posedge Clk);
      #1 Issue_valid = 1'b0;
      check("read_en_a", int'(Enable_Read_Data_A), 1);
      check("read_en_b", int'(Enable_Read_Data_B), 1);
      check("read_addr_a", int'(Data_A_address), int'(sa));
      check("read_addr_b", int'(Data_B_address), int'(sb));
      lat = 1;
      while (Done !== 1'b1 && lat < 16) begin
         @(posedge Clk);
         #1 lat++;
      end
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       legal;
      int         lat;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      int         lat;
      int         first_rd;
      int         seen_we;
      logic [7:0] prev_wd;
      logic       prev_z, prev_c;
      logic [7:0] e_res;
      logic       e_z, e_c;

      vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 3};
      vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 3};
      vecs[2]  = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 3};
      vecs[3]  = '{OP_SHL, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1, 3};
      vecs[4]  = '{OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 3};
      vecs[5]  = '{OP_OR,  8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b1, 3};
      vecs[6]  = '{OP_XOR, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1, 3};
      vecs[7]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 3};
      vecs[8]  = '{OP_MOV, 8'h12, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 3};
      vecs[9]  = '{OP_MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, MUL_ON, MUL_ON ? 10 : 3};
      vecs[10] = '{OP_MUL, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, MUL_ON, MUL_ON ? 10 : 3};

      Reset         = 1'b1;
      Issue_valid   = 1'b0;
      Opcode        = '0;
      Src_A_address = '0;
      Src_B_address = '0;
      Dest_address  = '0;
      for (int i = 0; i < 8; i++)
         preload(3'(i), 8'h00);
      @(posedge Clk);
      #1 Reset = 1'b0;

      check("rst_issue_ready", int'(Issue_ready), 1);
      check("rst_enable_write", int'(Enable_write), 0);
      check("rst_data_write", int'(Data_write), 0);
      check("rst_write_addr", int'(Data_write_address), 0);
      check("rst_addr_a", int'(Data_A_address), 0);
      check("rst_addr_b", int'(Data_B_address), 0);
      check("rst_read_en_a", int'(Enable_Read_Data_A), 0);
      check("rst_read_en_b", int'(Enable_Read_Data_B), 0);
      check("rst_zero", int'(Zero), 0);
      check("rst_carry", int'(Carry), 0);
      check("rst_illegal", int'(Illegal), 0);
      check("rst_done", int'(Done), 0);

      prev_wd = 8'h00;
      prev_z  = 1'b0;
      prev_c  = 1'b0;
      for (int i = 0; i < NV; i++) begin
         preload(3'd1, vecs[i].a);
         preload(3'd2, vecs[i].b);
         run_op(vecs[i].op, 3'd1, 3'd2, 3'd3, lat);
         e_res = vecs[i].legal ? vecs[i].res : prev_wd;
         e_z   = vecs[i].legal ? vecs[i].z : prev_z;
         e_c   = vecs[i].legal ? vecs[i].c : prev_c;
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_enable_write", i), int'(Enable_write), int'(vecs[i].legal));
         check($sformatf("v%0d_data_write", i), int'(Data_write), int'(e_res));
         check($sformatf("v%0d_write_addr", i), int'(Data_write_address), 3);
         check($sformatf("v%0d_zero", i), int'(Zero), int'(e_z));
         check($sformatf("v%0d_carry", i), int'(Carry), int'(e_c));
         check($sformatf("v%0d_illegal", i), int'(Illegal), int'(!vecs[i].legal));
         @(posedge Clk);
         #1;
         check($sformatf("v%0d_done_once", i), int'(Done), 0);
         check($sformatf("v%0d_write_once", i), int'(Enable_write), 0);
         check($sformatf("v%0d_ready_after", i), int'(Issue_ready), 1);
         check($sformatf("v%0d_rf_dest", i), int'(rf[3]), int'(e_res));
         prev_wd = e_res;
         prev_z  = e_z;
         prev_c  = e_c;
      end

      // Back-to-back dependency with Issue_valid held through the busy period.
      preload(3'd1, 8'h02);
      @(negedge Clk);
      Issue_valid   = 1'b1;
      Opcode        = OP_ADD;
      Src_A_address = 3'd1;
      Src_B_address = 3'd1;
      Dest_address  = 3'd1;
      @(posedge Clk);
      #1;
      Opcode        = OP_MOV;
      Src_A_address = 3'd0;
      Src_B_address = 3'd1;
      Dest_address  = 3'd4;
      first_rd = 0;
      for (int k = 2; k <= 12 && first_rd == 0; k++) begin
         @(posedge Clk);
         #1;
         if (Enable_Read_Data_A) begin
            first_rd    = k;
            Issue_valid = 1'b0;
         end
      end
      Issue_valid = 1'b0;
      check("b2b_second_read_cycle", first_rd, 5);
      check("b2b_read_addr_b", int'(Data_B_address), 1);
      lat = 0;
      while (Done !== 1'b1 && lat < 16) begin
         @(posedge Clk);
         #1 lat++;
      end
      check("b2b_mov_latency", lat, 2);
      check("b2b_mov_data", int'(Data_write), 'h04);
      check("b2b_mov_addr", int'(Data_write_address), 4);
      @(posedge Clk);
      #1;
      check("b2b_rf_r1", int'(rf[1]), 'h04);
      check("b2b_rf_r4", int'(rf[4]), 'h04);

      // Leave non-zero flags and data, then reset in the middle of a multiply.
      preload(3'd1, 8'hFE);
      preload(3'd2, 8'h03);
      run_op(OP_ADD, 3'd1, 3'd2, 3'd5, lat);
      check("pre_rst_data", int'(Data_write), 'h01);
      check("pre_rst_carry", int'(Carry), 1);
      preload(3'd1, 8'h10);
      preload(3'd2, 8'h11);
      @(negedge Clk);
      Issue_valid   = 1'b1;
      Opcode        = OP_MUL;
      Src_A_address = 3'd1;
      Src_B_address = 3'd2;
      Dest_address  = 3'd6;
      @(posedge Clk);
      #1 Issue_valid = 1'b0;
      repeat (4) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
      check("mid_rst_ready", int'(Issue_ready), 1);
      check("mid_rst_zero", int'(Zero), 0);
      check("mid_rst_carry", int'(Carry), 0);
      check("mid_rst_illegal", int'(Illegal), 0);
      check("mid_rst_data", int'(Data_write), 0);
      seen_we = 0;
      for (int k = 0; k < 12; k++) begin
         if (Enable_write || Done) seen_we++;
         @(posedge Clk);
         #1;
      end
      check("mid_rst_no_write", seen_we, 0);
      check("mid_rst_rf6", int'(rf[6]), 0);

      // Recovery after reset: multiplier (or illegal path) must start cleanly.
      preload(3'd1, 8'h03);
      preload(3'd2, 8'h05);
      run_op(OP_MUL, 3'd1, 3'd2, 3'd7, lat);
      check("post_rst_mul_latency", lat, MUL_ON ? 10 : 3);
      check("post_rst_mul_we", int'(Enable_write), int'(MUL_ON));
      check("post_rst_mul_data", int'(Data_write), MUL_ON ? 'h0F : 'h00);
      check("post_rst_mul_illegal", int'(Illegal), int'(!MUL_ON));
      check("post_rst_mul_carry", int'(Carry), 0);
      @(posedge Clk);
      #1;
      check("post_rst_rf7", int'(rf[7]), MUL_ON ? 'h0F : 'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
